// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO (write clock domain).
// Define FIFO_WR_OVF_DETECT_EN to build the sticky overflow register behind W_OVF.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   RD_PTR_SYNC,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic                  W_CLK_EN,
    output logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
    output logic                  W_FULL,
    output logic                  W_AFULL,
    output logic [ADDR_WIDTH:0]   W_LEVEL,
    output logic                  W_OVF
);

    localparam int         A      = ADDR_WIDTH;
    localparam logic [A:0] DEPTH  = {1'b1, {A{1'b0}}};
    localparam logic [A:0] MARGIN = (A+1)'(AFULL_MARGIN);

    logic [A:0] wbin;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] rbin;
    logic [A:0] level_next;
    logic [A:0] free_next;
    logic       full_next;
    logic       afull_next;

    assign W_CLK_EN = W_INC & ~W_FULL;
    assign W_ADDR   = wbin[A-1:0];

    // Flags are computed from the next-state pointer so they land on the same edge as the write.
    always_comb begin
        wbin_next  = wbin + (A+1)'(W_CLK_EN);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        for (int i = 0; i <= A; i++) begin
            rbin[i] = ^(RD_PTR_SYNC >> i);
        end
        level_next = wbin_next - rbin;
        free_next  = DEPTH - level_next;
        full_next  = (wgray_next == {~RD_PTR_SYNC[A:A-1], RD_PTR_SYNC[A-2:0]});
        afull_next = (free_next <= MARGIN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wbin        <= '0;
            WR_PTR_GRAY <= '0;
            W_FULL      <= 1'b0;
            W_AFULL     <= 1'b0;
            W_LEVEL     <= '0;
        end else begin
            wbin        <= wbin_next;
            WR_PTR_GRAY <= wgray_next;
            W_FULL      <= full_next;
            W_AFULL     <= afull_next;
            W_LEVEL     <= level_next;
        end
    end

`ifdef FIFO_WR_OVF_DETECT_EN
    logic ovf;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf <= 1'b0;
        end else if (W_INC & W_FULL) begin
            ovf <= 1'b1;
        end
    end

    assign W_OVF = ovf;
`else
    assign W_OVF = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl with ADDR_WIDTH=3, AFULL_MARGIN=2.
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       rst;
    logic       w_inc;
    logic [3:0] rd_ptr_sync;
    logic [2:0] w_addr;
    logic       w_clk_en;
    logic [3:0] wr_ptr_gray;
    logic       w_full;
    logic       w_afull;
    logic [3:0] w_level;
    logic       w_ovf;

    int checks = 0;
    int errors = 0;

`ifdef FIFO_WR_OVF_DETECT_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    fifo_wr_ctrl #(.ADDR_WIDTH(3), .AFULL_MARGIN(2)) dut (
        .CLK         (clk),
        .RST         (rst),
        .W_INC       (w_inc),
        .RD_PTR_SYNC (rd_ptr_sync),
        .W_ADDR      (w_addr),
        .W_CLK_EN    (w_clk_en),
        .WR_PTR_GRAY (wr_ptr_gray),
        .W_FULL      (w_full),
        .W_AFULL     (w_afull),
        .W_LEVEL     (w_level),
        .W_OVF       (w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        w_inc       = 1'b0;
        rd_ptr_sync = 4'b0000;
        rst         = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (w_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", w_addr); end
        checks++; if (wr_ptr_gray !== 4'd0) begin errors++; $display("FAIL reset_gray: got %b expected 0000", wr_ptr_gray); end
        checks++; if ({w_full, w_afull, w_ovf, w_clk_en} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {w_full, w_afull, w_ovf, w_clk_en}); end
        checks++; if (w_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", w_level); end
    endtask

    task automatic test_fill();
        rd_ptr_sync = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            w_inc = 1'b1;
            #1;
            checks++; if (w_clk_en !== 1'b1) begin errors++; $display("FAIL fill_en[%0d]: got %b expected 1", i, w_clk_en); end
            checks++; if (w_addr !== 3'(i)) begin errors++; $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, w_addr, i); end
            tick();
            checks++; if (w_level !== 4'(i + 1)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, w_level, i + 1); end
            checks++; if (w_afull !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, w_afull, (i + 1 >= 6)); end
            checks++; if (w_full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, w_full, (i == 7)); end
        end
        w_inc = 1'b0;
        checks++; if (wr_ptr_gray !== 4'b1100) begin errors++; $display("FAIL fill_gray: got %b expected 1100", wr_ptr_gray); end
    endtask

    task automatic test_overflow();
        w_inc = 1'b1;
        #1;
        checks++; if (w_clk_en !== 1'b0) begin errors++; $display("FAIL ovf_en: got %b expected 0", w_clk_en); end
        checks++; if (w_addr !== 3'd0) begin errors++; $display("FAIL ovf_addr: got %0d expected 0", w_addr); end
        tick();
        w_inc = 1'b0;
        checks++; if (w_ovf !== OVF_EN) begin errors++; $display("FAIL ovf_flag: got %b expected %b", w_ovf, OVF_EN); end
        checks++; if (wr_ptr_gray !== 4'b1100 || w_level !== 4'd8 || w_full !== 1'b1) begin
            errors++; $display("FAIL ovf_hold: got gray=%b level=%0d full=%b expected 1100/8/1", wr_ptr_gray, w_level, w_full);
        end
        tick();
        checks++; if (w_ovf !== OVF_EN) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", w_ovf, OVF_EN); end
    endtask

    task automatic test_drain();
        rd_ptr_sync = 4'b0010;
        tick();
        checks++; if (w_full !== 1'b0) begin errors++; $display("FAIL drain_full: got %b expected 0", w_full); end
        checks++; if (w_level !== 4'd5) begin errors++; $display("FAIL drain_level: got %0d expected 5", w_level); end
        checks++; if (w_afull !== 1'b0) begin errors++; $display("FAIL drain_afull: got %b expected 0", w_afull); end
    endtask

    // Read pointer trails the writer by three entries, so the level never exceeds 4.
    task automatic test_wrap();
        logic [3:0] wb;
        logic [3:0] rb;
        logic [3:0] prev_gray;
        apply_reset();
        wb = 4'd0;
        for (int k = 0; k < 20; k++) begin
            rb          = (k >= 3) ? 4'(k - 3) : 4'd0;
            rd_ptr_sync = to_gray(rb);
            w_inc       = 1'b1;
            prev_gray   = wr_ptr_gray;
            #1;
            checks++; if (w_addr !== 3'(k % 8)) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, w_addr, k % 8); end
            tick();
            wb = wb + 4'd1;
            checks++; if (wr_ptr_gray !== to_gray(wb) || $countones(wr_ptr_gray ^ prev_gray) != 1) begin
                errors++; $display("FAIL wrap_gray[%0d]: got %b (prev %b) expected %b", k, wr_ptr_gray, prev_gray, to_gray(wb));
            end
            checks++; if (w_level !== 4'(wb - rb)) begin errors++; $display("FAIL wrap_level[%0d]: got %0d expected %0d", k, w_level, 4'(wb - rb)); end
        end
        w_inc = 1'b0;
    endtask

    // Continues from the wrap state: write pointer 20 (mod 16 = 4), read pointer 16 (mod 16 = 0).
    task automatic test_back_to_back();
        rd_ptr_sync = to_gray(4'd0);
        w_inc       = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (w_level !== 4'd7) begin errors++; $display("FAIL sim_pre_level: got %0d expected 7", w_level); end
        rd_ptr_sync = to_gray(4'd1);
        tick();
        w_inc = 1'b0;
        checks++; if (w_level !== 4'd7 || w_full !== 1'b0) begin
            errors++; $display("FAIL sim_level_full: got level=%0d full=%b expected 7/0", w_level, w_full);
        end
        checks++; if (w_afull !== 1'b1) begin errors++; $display("FAIL sim_afull: got %b expected 1", w_afull); end
    endtask

    task automatic test_reset_mid();
        rd_ptr_sync = to_gray(4'd2);
        tick();
        rd_ptr_sync = to_gray(4'd3);
        tick();
        checks++; if (w_level !== 4'd5) begin errors++; $display("FAIL rmid_pre_level: got %0d expected 5", w_level); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({w_addr, wr_ptr_gray, w_level} !== 11'd0 || {w_full, w_afull, w_ovf, w_clk_en} !== 4'b0000) begin
            errors++; $display("FAIL rmid_clear: got addr=%0d gray=%b level=%0d flags=%b expected all 0",
                               w_addr, wr_ptr_gray, w_level, {w_full, w_afull, w_ovf, w_clk_en});
        end
        rd_ptr_sync = 4'b0000;
        @(negedge clk);
        rst   = 1'b1;
        w_inc = 1'b1;
        #1;
        checks++; if (w_addr !== 3'd0 || w_clk_en !== 1'b1) begin
            errors++; $display("FAIL rmid_first_write: got addr=%0d en=%b expected 0/1", w_addr, w_clk_en);
        end
        tick();
        w_inc = 1'b0;
        checks++; if (w_level !== 4'd1 || wr_ptr_gray !== 4'b0001) begin
            errors++; $display("FAIL rmid_after: got level=%0d gray=%b expected 1/0001", w_level, wr_ptr_gray);
        end
    endtask

    initial begin
        rst         = 1'b0;
        w_inc       = 1'b0;
        rd_ptr_sync = 4'b0000;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
